// File: rtl/reset_seq.sv
// Reset sequencer: filtered external, software and master resets,
// stretched, then domain resets released in order with fixed gaps.
module reset_seq #(
  parameter int NUM_OUT        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               ext_rst_n_i,
  input  logic               sw_rst_i,
  output logic [NUM_OUT-1:0] rst_n_o,
  output logic               ready_o,
  output logic [1:0]         cause_o
);

  localparam int CMAX = (STRETCH_CYCLES > GAP_CYCLES) ?
                        STRETCH_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(FILTER_CYCLES + 1);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [FW-1:0] FILT_MAX     = FW'(FILTER_CYCLES);

  localparam logic [1:0] CAUSE_MST = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          filt_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [NUM_OUT-1:0]     rst_n_q;
  logic [NUM_OUT-1:0]     rel_d;
  logic                   ready_q;
  logic [1:0]             cause_q;
  logic                   ext_req;
  logic                   req;

  assign ext_req = (filt_q == FILT_MAX);
  assign req     = ext_req | sw_rst_i;
  assign cnt_d   = cnt_q + 1'b1;
  // Shifting a one in from bit 0 keeps the release strictly ordered.
  assign rel_d   = (rst_n_q << 1) | NUM_OUT'(1);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q  <= '1;
      filt_q  <= '0;
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      cause_q <= CAUSE_MST;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_n_i};

      if (sync_q[SYNC_STAGES-1]) begin
        filt_q <= '0;
      end else if (filt_q != FILT_MAX) begin
        filt_q <= filt_q + 1'b1;
      end

      if (req) begin
        cause_q <= ext_req ? CAUSE_EXT : CAUSE_SW;
        rst_n_q <= '0;
        ready_q <= 1'b0;
        cnt_q   <= '0;
        state_q <= HOLD;
      end else begin
        unique case (state_q)
          HOLD: begin
            if (cnt_q == STRETCH_LAST) begin
              cnt_q   <= '0;
              rst_n_q <= NUM_OUT'(1);
              if (NUM_OUT == 1) begin
                ready_q <= 1'b1;
                state_q <= RUN;
              end else begin
                state_q <= RELEASE;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          RELEASE: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              rst_n_q <= rel_d;
              if (&rel_d) begin
                ready_q <= 1'b1;
                state_q <= RUN;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          RUN: begin
            rst_n_q <= '1;
            ready_q <= 1'b1;
          end
          default: begin
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        endcase
      end
    end
  end

  assign rst_n_o = rst_n_q;
  assign ready_o = ready_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: table of input phases with
// hand-computed outputs, plus corner sequences.
module tb_reset_seq;

  logic       clk;
  logic       rst;
  logic       rst1;
  logic       ext_n;
  logic       sw;
  logic [3:0] rn0;
  logic       rdy0;
  logic [1:0] cs0;
  logic [0:0] rn1;
  logic       rdy1;
  logic [1:0] cs1;

  int checks;
  int errors;

  reset_seq u0 (
    .clk        (clk),
    .rst_i      (rst),
    .ext_rst_n_i(ext_n),
    .sw_rst_i   (sw),
    .rst_n_o    (rn0),
    .ready_o    (rdy0),
    .cause_o    (cs0)
  );

  reset_seq #(
    .NUM_OUT       (1),
    .STRETCH_CYCLES(1)
  ) u1 (
    .clk        (clk),
    .rst_i      (rst1),
    .ext_rst_n_i(ext_n),
    .sw_rst_i   (sw),
    .rst_n_o    (rn1),
    .ready_o    (rdy1),
    .cause_o    (cs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ext;
    logic       sw;
    int         n;
    logic [3:0] rn;
    logic       rdy;
    logic [1:0] cs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic s,
                     input int n, input logic [3:0] rn,
                     input logic rdy, input logic [1:0] cs);
    vec_t v;
    v.rst = r; v.ext = e; v.sw = s; v.n = n;
    v.rn = rn; v.rdy = rdy; v.cs = cs;
    tbl.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] rn,
                     input logic rdy, input logic [1:0] cs);
    checks++;
    if (rn0 !== rn || rdy0 !== rdy || cs0 !== cs) begin
      errors++;
      $display("FAIL %s: got rst_n=%b ready=%b cause=%b want %b %b %b",
               nm, rn0, rdy0, cs0, rn, rdy, cs);
    end
  endtask

  task automatic chk1(input string nm, input logic rn,
                      input logic rdy, input logic [1:0] cs);
    checks++;
    if (rn1 !== rn || rdy1 !== rdy || cs1 !== cs) begin
      errors++;
      $display("FAIL %s: got rst_n=%b ready=%b cause=%b want %b %b %b",
               nm, rn1, rdy1, cs1, rn, rdy, cs);
    end
  endtask

  initial begin
    bit hit;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rst1   = 1'b1;
    ext_n  = 1'b1;
    sw     = 1'b0;

    // power-on sequence
    add(1, 1, 0,  3, 4'b0000, 0, 2'b00);
    add(0, 1, 0, 15, 4'b0000, 0, 2'b00);
    add(0, 1, 0,  1, 4'b0001, 0, 2'b00);
    add(0, 1, 0,  3, 4'b0001, 0, 2'b00);
    add(0, 1, 0,  1, 4'b0011, 0, 2'b00);
    add(0, 1, 0,  4, 4'b0111, 0, 2'b00);
    add(0, 1, 0,  3, 4'b0111, 0, 2'b00);
    add(0, 1, 0,  1, 4'b1111, 1, 2'b00);
    // short external glitch is filtered
    add(0, 0, 0,  3, 4'b1111, 1, 2'b00);
    add(0, 1, 0, 10, 4'b1111, 1, 2'b00);
    // long external reset
    add(0, 0, 0,  6, 4'b1111, 1, 2'b00);
    add(0, 0, 0,  1, 4'b0000, 0, 2'b01);
    add(0, 0, 0,  3, 4'b0000, 0, 2'b01);
    add(0, 1, 0, 18, 4'b0000, 0, 2'b01);
    add(0, 1, 0,  1, 4'b0001, 0, 2'b01);
    add(0, 1, 0, 12, 4'b1111, 1, 2'b01);
    // software reset from RUN
    add(0, 1, 1,  1, 4'b0000, 0, 2'b10);
    add(0, 1, 0, 15, 4'b0000, 0, 2'b10);
    add(0, 1, 0,  1, 4'b0001, 0, 2'b10);
    add(0, 1, 0, 11, 4'b0111, 0, 2'b10);
    add(0, 1, 0,  1, 4'b1111, 1, 2'b10);
    // software reset aborting a release at 0011
    add(0, 1, 1,  1, 4'b0000, 0, 2'b10);
    add(0, 1, 0, 20, 4'b0011, 0, 2'b10);
    add(0, 1, 1,  1, 4'b0000, 0, 2'b10);
    add(0, 1, 0, 15, 4'b0000, 0, 2'b10);
    add(0, 1, 0,  1, 4'b0001, 0, 2'b10);
    add(0, 1, 0, 12, 4'b1111, 1, 2'b10);

    for (int i = 0; i < tbl.size(); i++) begin
      rst   = tbl[i].rst;
      ext_n = tbl[i].ext;
      sw    = tbl[i].sw;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].rn, tbl[i].rdy, tbl[i].cs);
    end

    // software and external requests on the same edge
    ext_n = 1'b0;
    step(6);
    chk("ext_pre", 4'b1111, 1'b1, 2'b10);
    sw = 1'b1;
    step(1);
    chk("coincide", 4'b0000, 1'b0, 2'b01);
    sw    = 1'b0;
    ext_n = 1'b1;

    // master reset in the middle of a release
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      step(1);
      checks++;
      if ((rn0 & (rn0 + 4'd1)) != 4'd0) begin
        errors++;
        $display("FAIL monotonic: got rst_n=%b want ordered", rn0);
      end
      if (rn0 == 4'b0011) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_0011: got rst_n=%b want 0011 in 100", rn0);
    end
    chk("mid_seq", 4'b0011, 1'b0, 2'b01);
    rst = 1'b1;
    step(1);
    chk("rst_mid", 4'b0000, 1'b0, 2'b00);

    // single output, one-cycle stretch
    chk1("n1_reset", 1'b0, 1'b0, 2'b00);
    rst1 = 1'b0;
    step(1);
    chk1("n1_release", 1'b1, 1'b1, 2'b00);
    sw = 1'b1;
    step(1);
    chk1("n1_sw", 1'b0, 1'b0, 2'b10);
    sw = 1'b0;
    step(1);
    chk1("n1_rerelease", 1'b1, 1'b1, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
